// File: rtl/uart_baud_pkg.sv
// Shared constants and divisor types for the UART baud generator.
// The fractional path is enabled by the BAUD_FRAC_EN macro in the users.
package uart_baud_pkg;

  localparam int DEF_DIV_INT  = 16;
  localparam int DEF_DIV_FRAC = 0;
  localparam int MIN_DIV      = 2;

  localparam int BAUD_DIV_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  int_part;
    logic [BAUD_FRAC_W-1:0] frac_part;
  } baud_div_t;

  typedef enum logic [1:0] {
    PRESET_9600,
    PRESET_19200,
    PRESET_57600,
    PRESET_115200
  } baud_preset_e;

  // Old fixed selector values, 50 MHz clock at 16x oversampling
  localparam baud_div_t PRESET_DIV_9600 = '{
    int_part: 16'd325, frac_part: 4'd8
  };
  localparam baud_div_t PRESET_DIV_19200 = '{
    int_part: 16'd162, frac_part: 4'd12
  };
  localparam baud_div_t PRESET_DIV_57600 = '{
    int_part: 16'd54, frac_part: 4'd4
  };
  localparam baud_div_t PRESET_DIV_115200 = '{
    int_part: 16'd27, frac_part: 4'd2
  };

  function automatic baud_div_t preset_div(
    input baud_preset_e sel
  );
    baud_div_t d;
    d = PRESET_DIV_9600;
    unique case (sel)
      PRESET_9600:   d = PRESET_DIV_9600;
      PRESET_19200:  d = PRESET_DIV_19200;
      PRESET_57600:  d = PRESET_DIV_57600;
      PRESET_115200: d = PRESET_DIV_115200;
      default:       d = PRESET_DIV_9600;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator; carry stretches the next interval.
// Only built when BAUD_FRAC_EN is defined.
`ifdef BAUD_FRAC_EN
module baud_frac_acc
  import uart_baud_pkg::*;
#(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic              carry_q;
  logic              carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step_i) begin
      {carry_d, acc_d} = {1'b0, acc_q}
                       + {1'b0, frac_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q   <= FRAC_W'(DEF_DIV_FRAC);
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule
`endif

// File: rtl/baud_gen_frac.sv
// UART baud generator: os_tick/bit_tick from a loadable divisor.
// Define BAUD_FRAC_EN to build the fractional accumulator.
module baud_gen_frac
  import uart_baud_pkg::*;
#(
  parameter  int DIV_W  = 16,
  parameter  int FRAC_W = 4,
  parameter  int OSR    = 16,
  localparam int PH_W   = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              bit_tick,
  output logic [PH_W-1:0]   os_phase,
  output logic              load_pending,
  output logic              cfg_err
);

  localparam logic [DIV_W-1:0] MIN_D =
    DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] RST_INT =
    DIV_W'(DEF_DIV_INT);
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(OSR - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [PH_W-1:0]  ph_q;
  logic [PH_W-1:0]  ph_d;
  logic             run_q;
  logic             run_d;
  logic             os_q;
  logic             os_d;
  logic             bit_q;
  logic             bit_d;
  logic             pend_q;
  logic             pend_d;
  logic             err_q;
  logic             err_d;
  logic [DIV_W-1:0] act_int_q;
  logic [DIV_W-1:0] act_int_d;
  logic [DIV_W-1:0] sh_int_q;
  logic [DIV_W-1:0] sh_int_d;

  logic [DIV_W-1:0] eff_int;
  logic [DIV_W:0]   len;
  logic             carry;
  logic             counting;
  logic             term;
  logic             tick;
  logic             ld_now;
  logic             ld_def;
  logic             apply_sh;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac_q;
  logic [FRAC_W-1:0] act_frac_d;
  logic [FRAC_W-1:0] sh_frac_q;
  logic [FRAC_W-1:0] sh_frac_d;
  logic              acc_clr;

  assign acc_clr = !counting || apply_sh;

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (acc_clr),
    .step_i  (tick),
    .frac_i  (act_frac_q),
    .carry_o (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  // Divisors below MIN_DIV run as MIN_DIV and raise cfg_err
  always_comb begin
    eff_int  = (act_int_q < MIN_D) ? MIN_D
                                   : act_int_q;
    len      = {1'b0, eff_int}
             + (DIV_W+1)'(carry);
    term     = ({1'b0, cnt_q}
               == len - (DIV_W+1)'(1));
    counting = en && run_q && !resync;
    tick     = counting && term;
    ld_now   = div_load && (!en || resync);
    ld_def   = div_load && en && !resync;
    apply_sh = pend_q
             && (tick || !en || resync);
  end

  always_comb begin
    cnt_d     = '0;
    ph_d      = '0;
    run_d     = en;
    os_d      = tick;
    bit_d     = tick && (ph_q == PH_LAST);
    act_int_d = act_int_q;
    sh_int_d  = sh_int_q;
    pend_d    = pend_q;
    err_d     = err_q;
`ifdef BAUD_FRAC_EN
    act_frac_d = act_frac_q;
    sh_frac_d  = sh_frac_q;
`endif
    if (counting) begin
      cnt_d = term ? '0
                   : cnt_q + DIV_W'(1);
      ph_d  = term ? ph_q + PH_W'(1)
                   : ph_q;
    end
    if (apply_sh) begin
      act_int_d = sh_int_q;
      pend_d    = 1'b0;
      err_d     = (sh_int_q < MIN_D);
`ifdef BAUD_FRAC_EN
      act_frac_d = sh_frac_q;
`endif
    end
    if (ld_now) begin
      act_int_d = div_int;
      sh_int_d  = div_int;
      pend_d    = 1'b0;
      err_d     = (div_int < MIN_D);
`ifdef BAUD_FRAC_EN
      act_frac_d = div_frac;
      sh_frac_d  = div_frac;
`endif
    end
    // A load during a boundary tick waits for the following one
    if (ld_def) begin
      sh_int_d = div_int;
      pend_d   = 1'b1;
`ifdef BAUD_FRAC_EN
      sh_frac_d = div_frac;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      ph_q      <= '0;
      run_q     <= 1'b0;
      os_q      <= 1'b0;
      bit_q     <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      act_int_q <= RST_INT;
      sh_int_q  <= RST_INT;
    end else begin
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      run_q     <= run_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      act_int_q <= act_int_d;
      sh_int_q  <= sh_int_d;
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      act_frac_q <= FRAC_W'(DEF_DIV_FRAC);
      sh_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
    end else begin
      act_frac_q <= act_frac_d;
      sh_frac_q  <= sh_frac_d;
    end
  end
`endif

  assign os_tick      = os_q;
  assign bit_tick     = bit_q;
  assign os_phase     = ph_q;
  assign load_pending = pend_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac against a countdown model.
// Honours BAUD_FRAC_EN the same way as the design.
module tb_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int PH_W   = 4;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              en = 1'b0;
  logic              resync = 1'b0;
  logic              div_load = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              os_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   os_phase;
  logic              load_pending;
  logic              cfg_err;

  baud_gen_frac #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OSR    (OSR)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .resync       (resync),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .div_load     (div_load),
    .os_tick      (os_tick),
    .bit_tick     (bit_tick),
    .os_phase     (os_phase),
    .load_pending (load_pending),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit d_rst = 1'b0;
  bit d_en = 1'b0;
  int tq[$];
  int bq[$];

  // Model: interval countdown, phase, accumulator as integers
  int m_act, m_actf, m_sh, m_shf;
  int m_pend, m_err, m_run, m_rem;
  int m_ph, m_acc, m_carry;
  int exp_os, exp_bit;

  function automatic int mlen();
    return ((m_act < 2) ? 2 : m_act) + m_carry;
  endfunction

  task automatic mapply(input int i, input int f);
    m_act  = i;
    m_actf = FRAC_ON ? f : 0;
    m_err  = (i < 2) ? 1 : 0;
  endtask

  task automatic model_edge(input bit rs, input bit ld,
                            input int di, input int df);
    int s;
    exp_os  = 0;
    exp_bit = 0;
    if (!d_rst) begin
      m_act = 16; m_actf = 0; m_sh = 16; m_shf = 0;
      m_pend = 0; m_err = 0; m_run = 0; m_rem = 0;
      m_ph = 0; m_acc = 0; m_carry = 0;
    end else if (!d_en || rs || !m_run) begin
      if (ld && (!d_en || rs)) begin
        mapply(di, df);
        m_sh = di; m_shf = df; m_pend = 0;
      end else if (m_pend && (!d_en || rs)) begin
        mapply(m_sh, m_shf);
        m_pend = 0;
      end
      if (ld && d_en && !rs) begin
        m_sh = di; m_shf = df; m_pend = 1;
      end
      m_ph = 0; m_acc = 0; m_carry = 0;
      m_run = d_en ? 1 : 0;
      m_rem = mlen();
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        exp_os  = 1;
        exp_bit = (m_ph == OSR - 1) ? 1 : 0;
        m_ph = (m_ph + 1) % OSR;
        if (FRAC_ON) begin
          s = m_acc + m_actf;
          m_carry = s / (1 << FRAC_W);
          m_acc = s % (1 << FRAC_W);
        end
        if (m_pend) begin
          mapply(m_sh, m_shf);
          m_pend = 0; m_acc = 0; m_carry = 0;
        end
        m_rem = mlen();
      end
      if (ld) begin
        m_sh = di; m_shf = df; m_pend = 1;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic step(input bit rs, input bit ld,
                      input int di, input int df);
    @(negedge clk);
    resetn   = d_rst;
    en       = d_en;
    resync   = rs;
    div_load = ld;
    div_int  = di[DIV_W-1:0];
    div_frac = df[FRAC_W-1:0];
    @(posedge clk);
    model_edge(rs, ld, di, df);
    #1;
    cyc++;
    chk("os_tick", 32'(os_tick), 32'(exp_os));
    chk("bit_tick", 32'(bit_tick), 32'(exp_bit));
    chk("os_phase", 32'(os_phase), 32'(m_ph));
    chk("load_pending", 32'(load_pending), 32'(m_pend));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    if (os_tick === 1'b1) tq.push_back(cyc);
    if (bit_tick === 1'b1) bq.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int c0, t0, rc;
    bit rs, ld;

    d_rst = 0; d_en = 0;
    run(3);

    d_rst = 1; d_en = 1;
    c0 = cyc + 1;
    tq.delete();
    run(20);
    chk("first_tick_default", 32'(qat(tq, 0) - c0), 32'd16);

    run(3);
    d_rst = 0;
    run(2);
    chk("rst_os_tick", 32'(os_tick), 32'd0);
    chk("rst_os_phase", 32'(os_phase), 32'd0);
    d_rst = 1;
    c0 = cyc + 1;
    tq.delete();
    run(20);
    chk("tick_after_reset", 32'(qat(tq, 0) - c0), 32'd16);

    d_en = 0;
    step(0, 1, 4, 0);
    d_en = 1;
    c0 = cyc + 1;
    tq.delete(); bq.delete();
    run(140);
    chk("int_first", 32'(qat(tq, 0) - c0), 32'd4);
    chk("int_gap", 32'(qat(tq, 5) - qat(tq, 4)), 32'd4);
    chk("bit_first", 32'(qat(bq, 0) - c0), 32'd64);
    chk("bit_gap", 32'(qat(bq, 1) - qat(bq, 0)), 32'd64);

    d_en = 0;
    step(0, 1, 4, 8);
    d_en = 1;
    tq.delete();
    run(200);
    chk("frac_span16",
        32'(qat(tq, 17) - qat(tq, 1)),
        FRAC_ON ? 32'd72 : 32'd64);

    d_en = 0;
    step(0, 1, 4, 0);
    d_en = 1;
    tq.delete();
    for (int i = 0; i < 40 && tq.size() == 0; i++)
      step(0, 0, 0, 0);
    t0 = qat(tq, 0);
    step(0, 0, 0, 0);
    step(0, 1, 10, 0);
    chk("pend_after_load", 32'(load_pending), 32'd1);
    run(20);
    chk("defer_old_len", 32'(qat(tq, 1) - t0), 32'd4);
    chk("defer_new_len", 32'(qat(tq, 2) - t0), 32'd14);
    chk("pend_cleared", 32'(load_pending), 32'd0);

    d_en = 0;
    step(0, 1, 4, 0);
    d_en = 1;
    for (int i = 0; i < 200 && m_ph != 7; i++)
      step(0, 0, 0, 0);
    chk("phase_before_resync", 32'(os_phase), 32'd7);
    tq.delete(); bq.delete();
    step(1, 0, 0, 0);
    rc = cyc;
    chk("phase_after_resync", 32'(os_phase), 32'd0);
    run(70);
    chk("resync_tick", 32'(qat(tq, 0) - rc), 32'd4);
    chk("resync_bit", 32'(qat(bq, 0) - rc), 32'd64);

    step(0, 1, 1, 0);
    run(10);
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    tq.delete();
    run(6);
    chk("bad_div_gap", 32'(qat(tq, 1) - qat(tq, 0)), 32'd2);
    step(0, 1, 5, 0);
    run(8);
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    tq.delete();
    run(15);
    chk("div5_gap", 32'(qat(tq, 1) - qat(tq, 0)), 32'd5);

    d_en = 1;
    for (int i = 0; i < 1500; i++) begin
      d_rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 63) == 0) d_en = !d_en;
      rs = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 29) == 0);
      step(rs, ld, int'($urandom_range(0, 9)),
           int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
